// File: rtl/fpu_mul_issue.sv
// rtl/fpu_mul_issue.sv - operand issue queue in front of the double-precision fpu_mul pipeline
//
// Buffers multiply requests in a DEPTH-entry FIFO, presents one at a time to
// fpu_mul (enable and operands held until ready), and returns each product
// through a valid/ready result port in request order.
//
// Optional feature macro: FPU_MUL_ISSUE_TIMEOUT_EN (WAIT watchdog, qNaN + res_err abort).
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_opa, req_opb, req_rmode   request operands and rounding mode
//   mul_enable, mul_opa/opb/rmode drive fpu_mul
//   mul_ready, mul_outfp          from fpu_mul
//   res_valid/res_ready           result handshake
//   res_data, res_err             product and timeout-abort flag
//   busy                          FIFO non-empty or FSM not IDLE

module fpu_mul_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_opa,
    input  logic [63:0] req_opb,
    input  logic [1:0]  req_rmode,
    output logic        mul_enable,
    output logic [63:0] mul_opa,
    output logic [63:0] mul_opb,
    output logic [1:0]  mul_rmode,
    input  logic        mul_ready,
    input  logic [63:0] mul_outfp,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_data,
    output logic        res_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 130;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_GAP
    } state_t;

    // Request FIFO; storage is not reset, pointers are, so reset discards contents.
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_req_ready;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_rd_ptr_nxt;
    logic          w_full_nxt;
    logic [EW-1:0] w_head;

    state_t        r_state;
    logic          r_mul_enable;
    logic [63:0]   r_mul_opa;
    logic [63:0]   r_mul_opb;
    logic [1:0]    r_mul_rmode;
    logic          r_res_valid;
    logic [63:0]   r_res_data;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_push       = req_valid && r_req_ready;
    assign w_pop        = (r_state == S_IDLE) && !w_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                          (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_rmode, req_opa, req_opb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_req_ready <= !w_full_nxt;
        end
    end

`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
    localparam int          CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;

    logic [CNT_W-1:0] r_cnt;
    // The limit compare is registered, so the abort lands one cycle after the
    // count reaches TIMEOUT; keeps the compare off the result-capture path.
    logic             r_expired;
    logic             r_res_err;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mul_enable <= 1'b0;
            r_mul_opa    <= '0;
            r_mul_opb    <= '0;
            r_mul_rmode  <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
            r_cnt        <= '0;
            r_expired    <= 1'b0;
            r_res_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        {r_mul_rmode, r_mul_opa, r_mul_opb} <= w_head;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mul_enable <= 1'b1;
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
                    r_cnt        <= '0;
                    r_expired    <= 1'b0;
`endif
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    // A real product always wins over a coincident watchdog abort.
                    if (mul_ready) begin
                        r_res_data   <= mul_outfp;
                        r_res_valid  <= 1'b1;
                        r_mul_enable <= 1'b0;
                        r_state      <= S_HOLD;
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
                    end else if (r_expired) begin
                        r_res_data   <= QNAN;
                        r_res_err    <= 1'b1;
                        r_res_valid  <= 1'b1;
                        r_mul_enable <= 1'b0;
                        r_state      <= S_HOLD;
                    end else begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_expired <= (r_cnt == CNT_W'(TIMEOUT));
`endif
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
                        r_res_err   <= 1'b0;
`endif
                        r_state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    // enable stays low for this cycle so fpu_mul restarts its count.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mul_enable = r_mul_enable;
    assign mul_opa    = r_mul_opa;
    assign mul_opb    = r_mul_opb;
    assign mul_rmode  = r_mul_rmode;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = !w_empty || (r_state != S_IDLE);

`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
    assign res_err = r_res_err;
`else
    // Constant 0 for any legal TIMEOUT; the watchdog is absent in this build.
    assign res_err = (TIMEOUT < 0);
`endif

endmodule
